// File: rtl/bus_arbiter_pkg.sv
// Shared types and default constants for the round-robin bus arbiter.
package bus_arbiter_pkg;

  typedef enum logic {
    StIdle  = 1'b0,
    StOwned = 1'b1
  } arb_state_e;

  localparam int unsigned DefaultSize      = 8;
  localparam int unsigned DefaultDataWidth = 16;
  localparam int unsigned DefaultMaxHold   = 4;
  // Wide enough for MAX_HOLD up to 15.
  localparam int unsigned HoldWidth        = 4;

endpackage

// File: rtl/bus_arbiter_switch.sv
// Data-path switch: routes the requester word picked by sel onto the shared bus.
module bus_arbiter_switch #(
  parameter int unsigned SIZE       = 8,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic [SIZE*DATA_WIDTH-1:0] data_in,
  input  logic [$clog2(SIZE)-1:0]    sel,
  output logic [DATA_WIDTH-1:0]      data_out
);

  assign data_out = data_in[int'(sel)*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter with a bounded hold time and a gated shared data bus.
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int unsigned SIZE       = DefaultSize,
  parameter int unsigned DATA_WIDTH = DefaultDataWidth,
  parameter int unsigned MAX_HOLD   = DefaultMaxHold
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [SIZE-1:0]            req,
  input  logic [SIZE*DATA_WIDTH-1:0] data_in,
  output logic [SIZE-1:0]            gnt,
  output logic [$clog2(SIZE)-1:0]    sel,
  output logic                       busy,
  output logic [DATA_WIDTH-1:0]      data_out
);

  localparam int unsigned SelW = $clog2(SIZE);

  arb_state_e           state_q;
  logic [SIZE-1:0]      gnt_q;
  logic [SelW-1:0]      sel_q;
  logic [SelW-1:0]      ptr_q;
  logic [HoldWidth-1:0] hold_q;
  logic                 busy_q;

  logic [SIZE-1:0]       cand;
  logic [SelW-1:0]       winner;
  logic                  found;
  logic                  owner_req;
  logic                  at_limit;
  logic                  do_grant;
  logic                  do_release;
  logic [DATA_WIDTH-1:0] switch_out;

  // The current owner never competes against itself, so a forced handover
  // and a normal re-arbitration share the same search.
  assign cand = req & ~gnt_q;

  always_comb begin
    logic [SelW-1:0] idx;
    idx    = '0;
    found  = 1'b0;
    winner = ptr_q;
    for (int unsigned k = 0; k < SIZE; k++) begin
      idx = ptr_q + SelW'(k);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
  end

  assign owner_req  = req[sel_q];
  assign at_limit   = (hold_q == HoldWidth'(MAX_HOLD));
  assign do_grant   = found && ((state_q == StIdle) || !owner_req || at_limit);
  assign do_release = (state_q == StOwned) && !owner_req && !found;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      gnt_q   <= '0;
      sel_q   <= '0;
      ptr_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else if (do_grant) begin
      state_q <= StOwned;
      gnt_q   <= SIZE'(1) << winner;
      sel_q   <= winner;
      ptr_q   <= winner + 1'b1;
      hold_q  <= HoldWidth'(1);
      busy_q  <= 1'b1;
    end else if (do_release) begin
      // sel keeps its last value; the bus is zeroed through busy instead.
      state_q <= StIdle;
      gnt_q   <= '0;
      hold_q  <= '0;
      busy_q  <= 1'b0;
    end else if ((state_q == StOwned) && !at_limit) begin
      hold_q <= hold_q + 1'b1;
    end
  end

  bus_arbiter_switch #(
    .SIZE       (SIZE),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_switch (
    .data_in  (data_in),
    .sel      (sel_q),
    .data_out (switch_out)
  );

  assign gnt      = gnt_q;
  assign sel      = sel_q;
  assign busy     = busy_q;
  assign data_out = busy_q ? switch_out : '0;

endmodule
